// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS registers of DATA_WIDTH bits with
// byte strobes, read-only status registers sourced from reg_in, SLVERR on
// out-of-range or read-only writes, and a one-cycle write pulse per register.
module axi_lite_regbank #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int ALSB   = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - ALSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic              aw_held, w_held;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [1:0]        bresp_q;

    logic              aw_fire, w_fire, wr_commit, wr_ok;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;

    logic              ar_fire;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]        rresp_q;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ALSB-1:0], S_AXI_ARADDR[ALSB-1:0], reg_in};

    // Write FSM state register.
    always_ff @(posedge ACLK) begin
        // NOTE: state and all other flops use non-blocking assignments so every
        // register samples pre-edge values and simulation order cannot matter.
        if (ARESET) wr_state <= WR_IDLE;
        else        wr_state <= wr_next;
    end

    // Write decode: merge latched and live AW/W halves and resolve the target.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        aw_fire   = S_AXI_AWVALID && S_AXI_AWREADY;
        w_fire    = S_AXI_WVALID && S_AXI_WREADY;
        wr_idx    = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:ALSB];
        wr_data   = w_held ? w_data_q : S_AXI_WDATA;
        wr_strb   = w_held ? w_strb_q : S_AXI_WSTRB;
        wr_commit = (wr_state == WR_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
        wr_ok     = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) wr_ok = !RO_MASK[i];
        end
    end

    // Write FSM next state: commit moves to response, B handshake returns.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (wr_commit) wr_next = WR_RESP;
            WR_RESP: if (S_AXI_BVALID && S_AXI_BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    // Write FSM outputs: a channel is ready only while its half is not latched.
    always_comb begin
        S_AXI_AWREADY = !ARESET && (wr_state == WR_IDLE) && !aw_held;
        S_AXI_WREADY  = !ARESET && (wr_state == WR_IDLE) && !w_held;
        S_AXI_BVALID  = (wr_state == WR_RESP);
        S_AXI_BRESP   = bresp_q;
    end

    // Write datapath: AW/W latches, register update, response code and pulses.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bresp_q  <= RESP_OKAY;
            wr_pulse <= '0;
            // NOTE: the bank is built from flops, not RAM, so it is cleared in
            // reset like any other control state.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_pulse <= '0;
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_idx == IDX_W'(i)) begin
                            wr_pulse[i] <= 1'b1;
                            for (int b = 0; b < STRB_W; b++) begin
                                if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
                            end
                        end
                    end
                end
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:ALSB];
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end
        end
    end

    // Register contents as seen by the fabric; read-only slots drive zero.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!RO_MASK[i]) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) rd_state <= RD_IDLE;
        else        rd_state <= rd_next;
    end

    // Read FSM next state: AR handshake loads data, R handshake releases it.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_fire) rd_next = RD_DATA;
            RD_DATA: if (S_AXI_RVALID && S_AXI_RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    // Read FSM outputs and address decode.
    always_comb begin
        S_AXI_ARREADY = !ARESET && (rd_state == RD_IDLE);
        S_AXI_RVALID  = (rd_state == RD_DATA);
        S_AXI_RDATA   = rdata_q;
        S_AXI_RRESP   = rresp_q;
        ar_fire       = S_AXI_ARVALID && S_AXI_ARREADY;
        rd_idx        = S_AXI_ARADDR[ADDR_WIDTH-1:ALSB];
    end

    // Read capture at the AR handshake; sees pre-write register values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_fire) begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rdata_q <= RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
                    rresp_q <= RESP_OKAY;
                end
            end
        end
    end

endmodule
